// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-port round-robin front end for a single-port synchronous RAM.
//   Each requester raises req with we/addr/wdata and holds them until its
//   one-cycle ack. The winner's request is latched at grant and played out
//   on the RAM pins. This block drives ram_data only while a write command
//   is on the pins.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req0/1, we0/1             request and direction (1 = write), held until ack
//   addr0/1, wdata0/1         request address and write data, held with req
//   ack0/1                    one-cycle completion pulse
//   rdata0/1                  last read result per port, held until next read
//   busy                      high whenever a transaction is in flight
//   ram_addr, ram_data        RAM address and bidirectional data bus
//   ram_chip_select, ram_write_enable, ram_output_enable   RAM controls
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// CMD   | command on the RAM pins (write data driven for writes)
// RD    | read command held, RAM drives the bus, captured at end of cycle
// DONE  | controls released, ack to the granted port
`timescale 1ns/1ps
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_chip_select,
  output logic                  ram_write_enable,
  output logic                  ram_output_enable
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    // On a tie the port that did not win last time goes; otherwise whoever asks.
    winner       = (req0 && req1) ? ~last_grant_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d      = winner;
          last_grant_d = winner;
          we_d         = winner ? we1    : we0;
          addr_d       = winner ? addr1  : addr0;
          wdata_d      = winner ? wdata1 : wdata0;
          state_d      = CMD;
        end
      end
      CMD:  state_d = we_q ? DONE : RD;
      RD: begin
        if (grant_q) rdata1_d = ram_data;
        else         rdata0_d = ram_data;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign ram_chip_select   = (state_q == CMD) || (state_q == RD);
  assign ram_write_enable  = (state_q == CMD) && we_q;
  // RD is only ever entered for reads, so !we_q keeps WE and OE exclusive.
  assign ram_output_enable = ram_chip_select && !we_q;
  assign ram_addr          = addr_q;
  assign ram_data          = ram_write_enable ? wdata_q : {DATA_WIDTH{1'bz}};
  assign ack0              = (state_q == DONE) && !grant_q;
  assign ack1              = (state_q == DONE) && grant_q;
  assign rdata0            = rdata0_q;
  assign rdata1            = rdata1_q;

endmodule
